// File: rtl/spi_controller_tx_if.sv
// spi_controller_tx_if: frame request handshake plus the SPI pins driven by the controller.
interface spi_controller_tx_if;
    logic       start;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic       SCLK;
    logic       nCS;
    logic       COPI;
    modport master (output start, rw, addr, wdata, input busy, done, SCLK, nCS, COPI);
    modport slave (input start, rw, addr, wdata, output busy, done, SCLK, nCS, COPI);
endinterface

// File: rtl/spi_controller_tx.sv
// spi_controller_tx: Mode 0, MSB-first serializer of one {rw, addr, wdata} frame per request.
module spi_controller_tx #(
    parameter int CLK_DIV     = 4,
    parameter int CS_SETUP    = 4,
    parameter int CS_HOLD     = 4,
    parameter int IDLE_GAP    = 4,
    parameter int TRAIL_EDGES = 1
) (
    input logic               clk,
    input logic               rst,
    spi_controller_tx_if.slave bus
);
    localparam int N    = 16 + TRAIL_EDGES;
    localparam int M1   = CLK_DIV > CS_SETUP ? CLK_DIV : CS_SETUP;
    localparam int M2   = CS_HOLD > IDLE_GAP ? CS_HOLD : IDLE_GAP;
    localparam int MAXP = M1 > M2 ? M1 : M2;
    localparam int CW   = MAXP > 1 ? $clog2(MAXP) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, GAP} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    bit_q, bit_d;
    logic [15:0]   sh_q, sh_d;
    logic          sclk_q, sclk_d;
    logic          ncs_q, ncs_d;
    logic          copi_q, copi_d;
    logic          done_q, done_d;
    logic          cnt_z;
    logic          last;

    assign cnt_z = cnt_q == '0;
    assign last  = bit_q == 5'(N);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            sclk_q  <= 1'b0;
            ncs_q   <= 1'b1;
            copi_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            sclk_q  <= sclk_d;
            ncs_q   <= ncs_d;
            copi_q  <= copi_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = bus.start ? SETUP : IDLE;
            SETUP:    state_d = cnt_z ? SHIFT_HI : SETUP;
            SHIFT_HI: state_d = cnt_z ? SHIFT_LO : SHIFT_HI;
            SHIFT_LO: state_d = cnt_z ? (last ? HOLD : SHIFT_HI) : SHIFT_LO;
            HOLD:     state_d = cnt_z ? ((IDLE_GAP > 1) ? GAP : IDLE) : HOLD;
            GAP:      state_d = cnt_z ? IDLE : GAP;
            default:  state_d = IDLE;
        endcase
    end

    // Every timed phase reloads the shared counter on entry, so actions key off state changes.
    always_comb begin
        cnt_d  = cnt_z ? cnt_q : cnt_q - CW'(1);
        bit_d  = bit_q;
        sh_d   = sh_q;
        sclk_d = sclk_q;
        ncs_d  = ncs_q;
        copi_d = copi_q;
        done_d = 1'b0;
        if (state_d != state_q) begin
            case (state_d)
                SETUP: begin
                    sh_d   = {bus.addr, bus.wdata, 1'b0};
                    copi_d = bus.rw;
                    ncs_d  = 1'b0;
                    bit_d  = '0;
                    cnt_d  = CW'(CS_SETUP - 1);
                end
                SHIFT_HI: begin
                    sclk_d = 1'b1;
                    cnt_d  = CW'(CLK_DIV - 1);
                end
                SHIFT_LO: begin
                    sclk_d = 1'b0;
                    copi_d = sh_q[15];
                    sh_d   = {sh_q[14:0], 1'b0};
                    bit_d  = bit_q + 5'd1;
                    cnt_d  = CW'(CLK_DIV - 1);
                end
                HOLD: cnt_d = CW'(CS_HOLD - 1);
                GAP: begin
                    ncs_d = 1'b1;
                    cnt_d = CW'(IDLE_GAP - 2);
                end
                default: begin
                    ncs_d  = 1'b1;
                    done_d = 1'b1;
                end
            endcase
        end
    end

    assign bus.busy = state_q != IDLE;
    assign bus.done = done_q;
    assign bus.SCLK = sclk_q;
    assign bus.nCS  = ncs_q;
    assign bus.COPI = copi_q;
endmodule

// File: tb/tb_spi_controller_tx.sv
// tb_spi_controller_tx: default and minimum-parameter controllers checked cycle by cycle against a timeline model.
module tb_spi_controller_tx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       st  = 1'b0;
    logic       srw = 1'b0;
    logic [6:0] sad = '0;
    logic [7:0] swd = '0;
    int         vec = 0;
    int         bad = 0;
    int         cyc = 0;

    always #5 clk = ~clk;

    spi_controller_tx_if b0 ();
    spi_controller_tx_if b1 ();
    assign b0.start = st;
    assign b0.rw    = srw;
    assign b0.addr  = sad;
    assign b0.wdata = swd;
    assign b1.start = st;
    assign b1.rw    = srw;
    assign b1.addr  = sad;
    assign b1.wdata = swd;

    spi_controller_tx u0 (.clk(clk), .rst(rst), .bus(b0));
    spi_controller_tx #(.CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(1), .IDLE_GAP(1), .TRAIL_EDGES(0))
        u1 (.clk(clk), .rst(rst), .bus(b1));

    int PS[2]  = '{4, 1};
    int PD[2]  = '{4, 2};
    int PN[2]  = '{17, 16};
    int PH[2]  = '{4, 1};
    int PG[2]  = '{4, 1};
    int LAT[2] = '{147, 66};

    logic [4:0] obs [2];
    assign obs[0] = {b0.busy, b0.done, b0.SCLK, b0.nCS, b0.COPI};
    assign obs[1] = {b1.busy, b1.done, b1.SCLK, b1.nCS, b1.COPI};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int per(input int d);
        return PS[d] + 2 * PD[d] * PN[d] + PH[d] + PG[d];
    endfunction

    // Expected {busy, done, SCLK, nCS, COPI} t edges after acceptance.
    function automatic logic [4:0] expv(input int t, input logic [15:0] f, input int d);
        int r, p, ph, k;
        logic sclk, copi;
        r    = PS[d] + 2 * PD[d] * PN[d] + PH[d];
        p    = r + PG[d];
        ph   = t - PS[d];
        sclk = t >= PS[d] && ph < 2 * PD[d] * PN[d] && (ph % (2 * PD[d])) < PD[d];
        k    = t < PS[d] + PD[d] ? 0 : (t - PS[d] - PD[d]) / (2 * PD[d]) + 1;
        copi = k < 16 ? f[15 - k] : 1'b0;
        return {t < p - 1, t == p - 1, sclk, !(t < r), copi};
    endfunction

    int         m_t0  [2] = '{0, 0};
    bit         m_act [2] = '{0, 0};
    logic [15:0] m_f  [2] = '{16'h0, 16'h0};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int d = 0; d < 2; d++) begin
            if (rst) m_act[d] <= 1'b0;
            else if (st && (!m_act[d] || cyc - m_t0[d] >= per(d) - 1)) begin
                m_act[d] <= 1'b1;
                m_t0[d]  <= cyc + 1;
                m_f[d]   <= {srw, sad, swd};
            end
        end
    end

    initial begin
        logic        pv_sclk [2] = '{1'b0, 1'b0};
        logic        pv_ncs  [2] = '{1'b1, 1'b1};
        int          ecnt    [2] = '{0, 0};
        logic [15:0] word    [2] = '{16'h0, 16'h0};
        bit          abort   [2] = '{1'b0, 1'b0};
        logic [4:0]  e;
        forever begin
            @(posedge clk);
            #2;
            for (int d = 0; d < 2; d++) begin
                e = m_act[d] ? expv(cyc - m_t0[d], m_f[d], d) : 5'b00010;
                chk($sformatf("u%0d.busy@%0d", d, cyc), obs[d][4], e[4]);
                chk($sformatf("u%0d.done@%0d", d, cyc), obs[d][3], e[3]);
                chk($sformatf("u%0d.sclk@%0d", d, cyc), obs[d][2], e[2]);
                chk($sformatf("u%0d.ncs@%0d", d, cyc), obs[d][1], e[1]);
                chk($sformatf("u%0d.copi@%0d", d, cyc), obs[d][0], e[0]);
                if (obs[d][3] === 1'b1)
                    chk($sformatf("u%0d.done_lat", d), m_act[d] ? cyc - m_t0[d] : -1, LAT[d]);
                if (rst) abort[d] = 1'b1;
                if (pv_ncs[d] && obs[d][1] === 1'b0) begin
                    ecnt[d]  = 0;
                    word[d]  = '0;
                    abort[d] = 1'b0;
                end
                if (!pv_sclk[d] && obs[d][2] === 1'b1 && obs[d][1] === 1'b0) begin
                    if (ecnt[d] < 16) word[d] = {word[d][14:0], obs[d][0]};
                    ecnt[d]++;
                end
                if (pv_ncs[d] === 1'b0 && obs[d][1] === 1'b1 && !abort[d]) begin
                    chk($sformatf("u%0d.edges", d), ecnt[d], PN[d]);
                    chk($sformatf("u%0d.word", d), word[d], m_f[d]);
                end
                pv_sclk[d] = obs[d][2];
                pv_ncs[d]  = obs[d][1];
            end
        end
    end

    task automatic send(input logic r, input logic [6:0] a, input logic [7:0] w);
        st  = 1'b1;
        srw = r;
        sad = a;
        swd = w;
        @(negedge clk);
        st = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (!b0.busy && !b1.busy) return;
        end
        chk("idle_timeout", 1, 0);
    endtask

    task automatic wait_done0();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (b0.done) return;
        end
        chk("done_timeout", 1, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        @(negedge clk);
        send(1'b1, 7'h04, 8'h80);
        wait_idle();
        repeat (3) @(negedge clk);
        send(1'b1, 7'h00, 8'hA5);
        wait_done0();
        send(1'b1, 7'h01, 8'h3C);
        wait_idle();
        repeat (3) @(negedge clk);
        send(1'b1, 7'h05, 8'h11);
        repeat (19) @(negedge clk);
        send(1'b1, 7'h7F, 8'hEE);
        repeat (79) @(negedge clk);
        send(1'b0, 7'h33, 8'h44);
        wait_idle();
        wait_idle();
        repeat (3) @(negedge clk);
        send(1'b1, 7'h04, 8'h55);
        repeat (59) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        send(1'b1, 7'h04, 8'h66);
        wait_idle();
        repeat (2) @(negedge clk);
        send(1'b0, 7'h02, 8'hFF);
        wait_idle();
        for (int n = 0; n < 12; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(1'($urandom), 7'($urandom), 8'($urandom));
            for (int i = 0; i < 600 && (b0.busy || b1.busy); i++) begin
                st  = $urandom_range(0, 19) == 0;
                srw = 1'($urandom);
                sad = 7'($urandom);
                swd = 8'($urandom);
                @(negedge clk);
            end
            st = 1'b0;
            wait_idle();
            wait_idle();
        end
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
